// File: rtl/ray_dispatch_scheduler.sv
// Frame-level dispatcher for the ray-unit pool.
// Issues pixels in raster order to free cores with rotating priority.
//
// Ports:
//   clk_in, rst_in        : clock, synchronous active-high reset
//   enable_in             : permits starting a new frame
//   core_ready_in         : per-core accepting-work flags
//   core_retire_in        : per-core result-valid pulses
//   latch_params_out      : pulse, datapath captures frame parameters
//   frame_start_out       : pulse, coincident with latch_params_out
//   frame_done_out        : pulse once the last pixel has retired
//   assign_valid_out      : pixel assignment strobe
//   assign_core_out       : target core of the assignment
//   assign_hcount_out     : pixel column of the assignment
//   assign_vcount_out     : pixel row of the assignment
//   outstanding_out       : number of cores holding in-flight work
//   frame_count_out       : completed-frame counter (wraps)
//   busy_out              : high whenever the scheduler is not idle
module ray_dispatch_scheduler #(
    parameter int DISPLAY_WIDTH  = 320,
    parameter int DISPLAY_HEIGHT = 240,
    parameter int H_BITS         = 9,
    parameter int V_BITS         = 8,
    parameter int NUM_CORES      = 4,
    parameter int CORE_BITS      = $clog2(NUM_CORES)
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           enable_in,
    input  logic [NUM_CORES-1:0]           core_ready_in,
    input  logic [NUM_CORES-1:0]           core_retire_in,
    output logic                           latch_params_out,
    output logic                           frame_start_out,
    output logic                           frame_done_out,
    output logic                           assign_valid_out,
    output logic [CORE_BITS-1:0]           assign_core_out,
    output logic [H_BITS-1:0]              assign_hcount_out,
    output logic [V_BITS-1:0]              assign_vcount_out,
    output logic [$clog2(NUM_CORES+1)-1:0] outstanding_out,
    output logic [7:0]                     frame_count_out,
    output logic                           busy_out
);

    localparam int CNT_BITS = $clog2(NUM_CORES + 1);
    localparam logic [CORE_BITS:0] NC = (CORE_BITS + 1)'(NUM_CORES);
    localparam logic [H_BITS-1:0] H_LAST = H_BITS'(DISPLAY_WIDTH - 1);
    localparam logic [V_BITS-1:0] V_LAST = V_BITS'(DISPLAY_HEIGHT - 1);
    localparam logic [CORE_BITS-1:0] C_LAST = CORE_BITS'(NUM_CORES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_DISPATCH,
        S_DRAIN
    } state_t;

    state_t                 r_state;
    logic [NUM_CORES-1:0]   r_busy;
    logic [CORE_BITS-1:0]   r_rr;
    logic [H_BITS-1:0]      r_h;
    logic [V_BITS-1:0]      r_v;

    state_t                 w_state_nxt;
    logic [NUM_CORES-1:0]   w_elig;
    logic                   w_found;
    logic [CORE_BITS-1:0]   w_win;
    logic [CORE_BITS:0]     w_idx;
    logic [NUM_CORES-1:0]   w_win_oh;
    logic [NUM_CORES-1:0]   w_retire;
    logic [NUM_CORES-1:0]   w_busy_nxt;
    logic [CNT_BITS-1:0]    w_cnt;
    logic [CORE_BITS-1:0]   w_rr_nxt;
    logic                   w_last_h;
    logic                   w_last_v;

    // Eligibility uses the registered busy mask, so a core retired this
    // cycle only competes again on the following cycle.
    assign w_elig = (r_state == S_DISPATCH) ?
                    (core_ready_in & ~r_busy) : '0;

    // Scan from the far end of the rotation back toward r_rr so the last
    // hit, i.e. the nearest index at or after r_rr, wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_rr} + (CORE_BITS + 1)'(i);
            if (w_idx >= NC) begin
                w_idx = w_idx - NC;
            end
            if (w_elig[w_idx[CORE_BITS-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[CORE_BITS-1:0];
            end
        end
    end

    assign w_win_oh = w_found ?
                      (NUM_CORES'(1) << w_win) : '0;
    // Retire pulses from cores we do not consider busy are dropped.
    assign w_retire   = core_retire_in & r_busy;
    assign w_busy_nxt = (r_busy & ~w_retire) | w_win_oh;
    assign w_rr_nxt   = (w_win == C_LAST) ?
                        '0 : w_win + CORE_BITS'(1);
    assign w_last_h   = (r_h == H_LAST);
    assign w_last_v   = (r_v == V_LAST);

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_cnt = w_cnt + CNT_BITS'(w_busy_nxt[i]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (enable_in) begin
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                w_state_nxt = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (w_found && w_last_h && w_last_v) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_busy == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state           <= S_IDLE;
            r_busy            <= '0;
            r_rr              <= '0;
            r_h               <= '0;
            r_v               <= '0;
            latch_params_out  <= 1'b0;
            frame_start_out   <= 1'b0;
            frame_done_out    <= 1'b0;
            assign_valid_out  <= 1'b0;
            assign_core_out   <= '0;
            assign_hcount_out <= '0;
            assign_vcount_out <= '0;
            outstanding_out   <= '0;
            frame_count_out   <= '0;
            busy_out          <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_busy           <= w_busy_nxt;
            outstanding_out  <= w_cnt;
            busy_out         <= (w_state_nxt != S_IDLE);
            latch_params_out <= 1'b0;
            frame_start_out  <= 1'b0;
            frame_done_out   <= 1'b0;
            assign_valid_out <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (enable_in) begin
                        latch_params_out <= 1'b1;
                        frame_start_out  <= 1'b1;
                    end
                end
                S_LATCH: begin
                    r_h <= '0;
                    r_v <= '0;
                end
                S_DISPATCH: begin
                    if (w_found) begin
                        assign_valid_out  <= 1'b1;
                        assign_core_out   <= w_win;
                        assign_hcount_out <= r_h;
                        assign_vcount_out <= r_v;
                        r_rr              <= w_rr_nxt;
                        if (w_last_h) begin
                            r_h <= '0;
                            if (!w_last_v) begin
                                r_v <= r_v + V_BITS'(1);
                            end
                        end else begin
                            r_h <= r_h + H_BITS'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_busy == '0) begin
                        frame_done_out  <= 1'b1;
                        frame_count_out <= frame_count_out + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_dispatch_scheduler.sv
// Directed testbench for ray_dispatch_scheduler (W=4, H=2, 4 cores).
// A small core model retires each assignment after a fixed delay.
module tb_ray_dispatch_scheduler;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       enable_in = 1'b0;
    logic [3:0] core_ready_in = '0;
    logic [3:0] core_retire_in = '0;
    logic       latch_params_out;
    logic       frame_start_out;
    logic       frame_done_out;
    logic       assign_valid_out;
    logic [1:0] assign_core_out;
    logic [8:0] assign_hcount_out;
    logic [7:0] assign_vcount_out;
    logic [2:0] outstanding_out;
    logic [7:0] frame_count_out;
    logic       busy_out;

    ray_dispatch_scheduler #(
        .DISPLAY_WIDTH (4),
        .DISPLAY_HEIGHT(2),
        .H_BITS        (9),
        .V_BITS        (8),
        .NUM_CORES     (4)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .enable_in        (enable_in),
        .core_ready_in    (core_ready_in),
        .core_retire_in   (core_retire_in),
        .latch_params_out (latch_params_out),
        .frame_start_out  (frame_start_out),
        .frame_done_out   (frame_done_out),
        .assign_valid_out (assign_valid_out),
        .assign_core_out  (assign_core_out),
        .assign_hcount_out(assign_hcount_out),
        .assign_vcount_out(assign_vcount_out),
        .outstanding_out  (outstanding_out),
        .frame_count_out  (frame_count_out),
        .busy_out         (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    int         n_assign, n_latch, n_done, n_start_mis;
    int         max_out, cyc, done_cyc, first_latch, latch2;
    bit         timeout, done_busy;
    int         a_cyc [64];
    logic [1:0] a_core[64];
    logic [8:0] a_h   [64];
    logic [7:0] a_v   [64];
    int         timer [4];

    function automatic logic [34:0] snap_outs();
        return {latch_params_out, frame_start_out, frame_done_out,
                assign_valid_out, assign_core_out, assign_hcount_out,
                assign_vcount_out, outstanding_out, frame_count_out,
                busy_out};
    endfunction

    task automatic do_reset();
        rst_in = 1'b1;
        enable_in = 1'b0;
        core_ready_in = '0;
        core_retire_in = '0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    // Runs one frame: raises enable, models cores, records activity.
    task automatic run_frame(input logic [3:0] ready, input int delay,
                             input int drop_after, input logic [3:0] bogus,
                             input bit keep_en);
        int   extra;
        bit   done;
        logic [3:0] ret;
        n_assign = 0; n_latch = 0; n_done = 0; n_start_mis = 0;
        max_out = 0; cyc = 0; done_cyc = -1; first_latch = -1;
        latch2 = -1; timeout = 0; done_busy = 1'b1;
        for (int c = 0; c < 4; c++) timer[c] = 0;
        extra = 0;
        done = 0;
        core_ready_in = ready;
        core_retire_in = '0;
        enable_in = 1'b1;
        while (!(done && extra >= 4)) begin
            @(negedge clk_in);
            cyc++;
            if (done) extra++;
            if (cyc > 400) begin
                timeout = 1;
                break;
            end
            ret = '0;
            for (int c = 0; c < 4; c++) begin
                if (timer[c] > 0) begin
                    timer[c]--;
                    if (timer[c] == 0) ret[c] = 1'b1;
                end
            end
            if (latch_params_out) begin
                n_latch++;
                if (first_latch < 0) first_latch = cyc;
                else if (latch2 < 0) latch2 = cyc;
            end
            if (latch_params_out !== frame_start_out) n_start_mis++;
            if (int'(outstanding_out) > max_out)
                max_out = int'(outstanding_out);
            if (assign_valid_out && n_assign < 64) begin
                a_cyc[n_assign]  = cyc;
                a_core[n_assign] = assign_core_out;
                a_h[n_assign]    = assign_hcount_out;
                a_v[n_assign]    = assign_vcount_out;
                timer[assign_core_out] = delay;
                n_assign++;
            end
            if (frame_done_out) begin
                n_done++;
                if (!done) begin
                    done = 1;
                    done_cyc = cyc;
                    done_busy = busy_out;
                end
            end
            if (n_assign == drop_after) enable_in = 1'b0;
            if (frame_done_out && !keep_en) enable_in = 1'b0;
            if (cyc % 3 == 0) ret = ret | bogus;
            core_retire_in = ret;
        end
        if (!keep_en) enable_in = 1'b0;
        core_retire_in = '0;
    endtask

    task automatic test_reset();
        logic [34:0] s;
        do_reset();
        rst_in = 1'b1;
        @(negedge clk_in);
        s = snap_outs();
        checks++;
        if (s !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %h expected 0", s);
        end
        rst_in = 1'b0;
        @(negedge clk_in);
        s = snap_outs();
        checks++;
        if (s !== '0) begin
            errors++;
            $display("FAIL idle_outs: got %h expected 0", s);
        end
    endtask

    task automatic test_basic();
        do_reset();
        run_frame(4'b1111, 3, -1, 4'b0000, 0);
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL basic_timeout: got 1 expected 0");
        end
        checks++;
        if (first_latch !== 1) begin
            errors++;
            $display("FAIL basic_latch_cyc: got %0d expected 1",
                     first_latch);
        end
        checks++;
        if (n_start_mis !== 0) begin
            errors++;
            $display("FAIL basic_start_align: got %0d expected 0",
                     n_start_mis);
        end
        checks++;
        if (n_assign !== 8) begin
            errors++;
            $display("FAIL basic_n_assign: got %0d expected 8", n_assign);
        end
        checks++;
        if (a_cyc[0] !== 3) begin
            errors++;
            $display("FAIL basic_first_cyc: got %0d expected 3", a_cyc[0]);
        end
        for (int i = 0; i < 8 && i < n_assign; i++) begin
            checks++;
            if (a_core[i] !== 2'(i % 4) || a_h[i] !== 9'(i % 4)
                || a_v[i] !== 8'(i / 4)) begin
                errors++;
                $display("FAIL basic_assign%0d: got c%0d (%0d,%0d) expected c%0d (%0d,%0d)",
                         i, a_core[i], a_h[i], a_v[i],
                         i % 4, i % 4, i / 4);
            end
        end
        checks++;
        if (n_done !== 1 || done_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got %0d busy %0d expected 1 busy 0",
                     n_done, done_busy);
        end
        checks++;
        if (frame_count_out !== 8'd1 || n_latch !== 1) begin
            errors++;
            $display("FAIL basic_count: got %0d latches %0d expected 1 1",
                     frame_count_out, n_latch);
        end
    endtask

    task automatic test_single_core();
        do_reset();
        run_frame(4'b0100, 5, -1, 4'b0000, 0);
        checks++;
        if (timeout || n_assign !== 8) begin
            errors++;
            $display("FAIL single_n_assign: got %0d expected 8", n_assign);
        end
        for (int i = 0; i < 8 && i < n_assign; i++) begin
            checks++;
            if (a_core[i] !== 2'd2) begin
                errors++;
                $display("FAIL single_core%0d: got %0d expected 2",
                         i, a_core[i]);
            end
            if (i > 0) begin
                checks++;
                if (a_cyc[i] - a_cyc[i-1] < 6) begin
                    errors++;
                    $display("FAIL single_gap%0d: got %0d expected >=6",
                             i, a_cyc[i] - a_cyc[i-1]);
                end
            end
        end
        checks++;
        if (max_out > 1) begin
            errors++;
            $display("FAIL single_outstanding: got %0d expected <=1",
                     max_out);
        end
        checks++;
        if (n_done !== 1 || done_cyc < a_cyc[7] + 6) begin
            errors++;
            $display("FAIL single_done: got %0d at %0d expected 1 after %0d",
                     n_done, done_cyc, a_cyc[7] + 5);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        run_frame(4'b1001, 1, -1, 4'b0000, 0);
        checks++;
        if (timeout || n_assign !== 8) begin
            errors++;
            $display("FAIL rot_n_assign: got %0d expected 8", n_assign);
        end
        for (int i = 0; i < 8 && i < n_assign; i++) begin
            checks++;
            if (a_core[i] !== ((i % 2 == 0) ? 2'd0 : 2'd3)) begin
                errors++;
                $display("FAIL rot_core%0d: got %0d expected %0d",
                         i, a_core[i], (i % 2 == 0) ? 0 : 3);
            end
        end
        checks++;
        if (max_out > 2 || frame_count_out !== 8'd1) begin
            errors++;
            $display("FAIL rot_end: got out %0d fc %0d expected <=2 1",
                     max_out, frame_count_out);
        end
    endtask

    task automatic test_bogus_retire();
        do_reset();
        run_frame(4'b0001, 2, -1, 4'b0010, 0);
        checks++;
        if (timeout || n_assign !== 8) begin
            errors++;
            $display("FAIL bogus_n_assign: got %0d expected 8", n_assign);
        end
        for (int i = 0; i < 8 && i < n_assign; i++) begin
            checks++;
            if (a_core[i] !== 2'd0 || a_h[i] !== 9'(i % 4)) begin
                errors++;
                $display("FAIL bogus_assign%0d: got c%0d h%0d expected c0 h%0d",
                         i, a_core[i], a_h[i], i % 4);
            end
            if (i > 0) begin
                checks++;
                if (a_cyc[i] - a_cyc[i-1] !== 4) begin
                    errors++;
                    $display("FAIL bogus_gap%0d: got %0d expected 4",
                             i, a_cyc[i] - a_cyc[i-1]);
                end
            end
        end
        checks++;
        if (max_out !== 1) begin
            errors++;
            $display("FAIL bogus_outstanding: got %0d expected 1", max_out);
        end
        checks++;
        if (n_done !== 1 || frame_count_out !== 8'd1) begin
            errors++;
            $display("FAIL bogus_done: got %0d fc %0d expected 1 1",
                     n_done, frame_count_out);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        run_frame(4'b1111, 3, 3, 4'b0000, 0);
        checks++;
        if (timeout || n_assign !== 8) begin
            errors++;
            $display("FAIL drop_n_assign: got %0d expected 8", n_assign);
        end
        checks++;
        if (n_done !== 1 || n_latch !== 1) begin
            errors++;
            $display("FAIL drop_pulses: got done %0d latch %0d expected 1 1",
                     n_done, n_latch);
        end
        checks++;
        if (busy_out !== 1'b0 || frame_count_out !== 8'd1) begin
            errors++;
            $display("FAIL drop_idle: got busy %0d fc %0d expected 0 1",
                     busy_out, frame_count_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_frame(4'b1111, 3, -1, 4'b0000, 1);
        checks++;
        if (timeout || n_done !== 1) begin
            errors++;
            $display("FAIL b2b_done: got %0d expected 1", n_done);
        end
        checks++;
        if (latch2 !== done_cyc + 1) begin
            errors++;
            $display("FAIL b2b_relatch: got %0d expected %0d",
                     latch2, done_cyc + 1);
        end
        do_reset();
        checks++;
        if (frame_count_out !== 8'd0 || outstanding_out !== 3'd0
            || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_abort: got fc %0d out %0d busy %0d expected 0 0 0",
                     frame_count_out, outstanding_out, busy_out);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        logic [34:0] s;
        found = 0;
        do_reset();
        core_ready_in = 4'b1111;
        enable_in = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk_in);
            if (assign_valid_out && assign_hcount_out == 9'd2
                && assign_vcount_out == 8'd0) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reach: got 0 expected 1");
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        s = snap_outs();
        checks++;
        if (s !== '0) begin
            errors++;
            $display("FAIL mid_reset_outs: got %h expected 0", s);
        end
        rst_in = 1'b0;
        enable_in = 1'b0;
        @(negedge clk_in);
        run_frame(4'b1111, 3, -1, 4'b0000, 0);
        checks++;
        if (first_latch !== 1 || n_assign < 1) begin
            errors++;
            $display("FAIL mid_relatch: got %0d expected 1", first_latch);
        end
        checks++;
        if (a_core[0] !== 2'd0 || a_h[0] !== 9'd0 || a_v[0] !== 8'd0) begin
            errors++;
            $display("FAIL mid_restart: got c%0d (%0d,%0d) expected c0 (0,0)",
                     a_core[0], a_h[0], a_v[0]);
        end
        checks++;
        if (timeout || n_assign !== 8 || frame_count_out !== 8'd1) begin
            errors++;
            $display("FAIL mid_frame: got %0d fc %0d expected 8 1",
                     n_assign, frame_count_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_core();
        test_rotation();
        test_bogus_retire();
        test_enable_drop();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
